// File: rtl/img_line_feed_ctrl_pkg.sv
// img_proc_pkg: shared state encoding, default geometry and counter sizing for the line feeder
package img_proc_pkg;
    typedef enum logic [2:0] {IDLE, PREFILL, WAIT_REQ, SEND_LINE, SEND_PAD, DRAIN} state_t;
    localparam int IMG_WIDTH_DEF = 512;
    localparam int IMG_HEIGHT_DEF = 512;
    localparam int DATA_W_DEF = 8;
    localparam int PEND_W = 2;
    localparam logic [PEND_W-1:0] PEND_MAX = 2'd3;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/img_line_feed_ctrl_if.sv
// img_line_feed_ctrl_if: upstream source, processing core and status signals of the line feeder
interface img_line_feed_ctrl_if import img_proc_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
    logic              start;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              pixel_valid;
    logic [DATA_W-1:0] pixel_input;
    logic              pixel_request;
    logic              pixel_out_valid;
    logic              busy;
    logic              frame_done;
    logic [15:0]       line_cnt;
    logic              err_overrun;
    modport master (
        input  start, src_valid, src_data, pixel_request, pixel_out_valid,
        output src_ready, pixel_valid, pixel_input, busy, frame_done, line_cnt, err_overrun
    );
    modport slave (
        output start, src_valid, src_data, pixel_request, pixel_out_valid,
        input  src_ready, pixel_valid, pixel_input, busy, frame_done, line_cnt, err_overrun
    );
endinterface

// File: rtl/img_line_feed_ctrl_req_tracker.sv
// img_req_tracker: counts pixel_request rising edges into a saturating pending count with a sticky overrun flag
module img_req_tracker import img_proc_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] pending,
    output logic              overrun
);
    logic req_prev_q, req_prev_d, overrun_q, overrun_d, rise;
    logic [PEND_W-1:0] pend_q, pend_d;
    always_comb begin
        req_prev_d = req;
        rise = en & req & ~req_prev_q;
        // an edge and a consumption in the same cycle cancel out
        pend_d = clr ? '0
               : (rise && !dec && pend_q != PEND_MAX) ? pend_q + 1'b1
               : (dec && !rise) ? pend_q - 1'b1
               : pend_q;
        overrun_d = overrun_q | (rise & ~dec & ~clr & (pend_q == PEND_MAX));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev_q <= 1'b0;
            pend_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            req_prev_q <= req_prev_d;
            pend_q <= pend_d;
            overrun_q <= overrun_d;
        end
    end
    assign pending = pend_q;
    assign overrun = overrun_q;
endmodule

// File: rtl/img_line_feed_ctrl.sv
// img_line_feed_ctrl: prefills the core's line buffers, releases one line per request, pads, and counts outputs to frame end
module img_line_feed_ctrl import img_proc_pkg::*; #(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PREFILL_LINES = 4,
    parameter int PAD_LINES = 2,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic clk,
    input logic rst,
    img_line_feed_ctrl_if.master bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int OUT_W = cnt_w(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(IMG_WIDTH * IMG_HEIGHT - 1);
    state_t state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [15:0] line_q, line_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] pi_q, pi_d;
    logic pv_q, pv_d, frame_done_q, frame_done_d;
    logic [PEND_W-1:0] pending;
    logic accept, pad, wrap, dec;
    assign bus.src_ready = state_q inside {PREFILL, SEND_LINE};
    assign accept = bus.src_ready & bus.src_valid;
    assign pad = state_q == SEND_PAD;
    assign wrap = (accept | pad) && col_q == COL_LAST;
    assign dec = state_q == WAIT_REQ && pending != '0;
    img_req_tracker u_req (
        .clk(clk),
        .rst(rst),
        .en(state_q != IDLE),
        .req(bus.pixel_request),
        .dec(dec),
        .clr(frame_done_d),
        .pending(pending),
        .overrun(bus.err_overrun)
    );
    always_comb begin
        state_d = state_q;
        pv_d = accept | pad;
        pi_d = accept ? bus.src_data : '0;
        col_d = (accept | pad) ? (wrap ? '0 : col_q + 1'b1) : col_q;
        line_d = line_q + 16'(wrap);
        out_d = out_q + OUT_W'(state_q != IDLE && bus.pixel_out_valid);
        frame_done_d = state_q != IDLE && bus.pixel_out_valid && out_q == OUT_LAST;
        case (state_q)
            IDLE:                state_d = bus.start ? PREFILL : IDLE;
            PREFILL:             state_d = (wrap && line_q == 16'(PREFILL_LINES - 1)) ? WAIT_REQ : PREFILL;
            WAIT_REQ:            state_d = !dec ? WAIT_REQ
                                         : line_q < 16'(IMG_HEIGHT) ? SEND_LINE
                                         : line_q < 16'(IMG_HEIGHT + PAD_LINES) ? SEND_PAD
                                         : DRAIN;
            SEND_LINE, SEND_PAD: state_d = wrap ? WAIT_REQ : state_q;
            default:             state_d = state_q;
        endcase
        // the output count ends the frame from any active state, not only DRAIN
        if (frame_done_d) begin
            state_d = IDLE;
            col_d = '0;
            line_d = '0;
            out_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q <= '0;
            line_q <= '0;
            out_q <= '0;
            pv_q <= 1'b0;
            pi_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q <= col_d;
            line_q <= line_d;
            out_q <= out_d;
            pv_q <= pv_d;
            pi_q <= pi_d;
            frame_done_q <= frame_done_d;
        end
    end
    assign bus.pixel_valid = pv_q;
    assign bus.pixel_input = pi_q;
    assign bus.busy = state_q != IDLE;
    assign bus.frame_done = frame_done_q;
    assign bus.line_cnt = line_q;
endmodule

// File: tb/tb_img_line_feed_ctrl.sv
// tb_img_line_feed_ctrl: directed frame sequence on an 8x8 image with a queue scoreboard of issued pixels
module tb_img_line_feed_ctrl;
    localparam int W = 8;
    localparam int H = 8;
    localparam int PAD = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    img_line_feed_ctrl_if #(.DATA_W(8)) bus ();
    img_line_feed_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PREFILL_LINES(4), .PAD_LINES(PAD), .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    logic [7:0] exp_q[$];
    int passed = 0;
    int total = 0;
    int beat_cnt = 0;
    bit rand_v = 1'b0;
    bit quiet_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.src_data = 8'($urandom);
        if (rand_v) bus.src_valid = 1'($urandom);
    endtask

    task automatic pulse_req();
        bus.pixel_request = 1'b1;
        step();
        bus.pixel_request = 1'b0;
        step();
    endtask

    task automatic wait_beats(input int n, input int lim, input string tag);
        for (int i = 0; i < lim && beat_cnt < n; i++) step();
        chk(tag, beat_cnt, n);
    endtask

    // pops the expected pixel for each output beat, then records the beat the next edge will accept
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            beat_cnt = 0;
        end else begin
            if (bus.pixel_valid) begin
                chk("beat_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("beat_data", bus.pixel_input, exp_q.pop_front());
                beat_cnt++;
                if (beat_cnt == W * H) repeat (PAD * W) exp_q.push_back(8'h00);
            end
            if (bus.src_valid && bus.src_ready) exp_q.push_back(bus.src_data);
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_data = '0;
        bus.pixel_request = 1'b0;
        bus.pixel_out_valid = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_pixel_valid", bus.pixel_valid, 0);
        chk("rst_pixel_input", bus.pixel_input, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_line_cnt", bus.line_cnt, 0);
        chk("rst_err_overrun", bus.err_overrun, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            quiet_seen |= bus.src_ready | bus.pixel_valid | bus.busy;
        end
        chk("idle_quiet", quiet_seen, 0);

        bus.src_valid = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        wait_beats(32, 100, "prefill_beats");
        repeat (10) step();
        chk("prefill_no_extra", beat_cnt, 32);
        chk("prefill_line_cnt", bus.line_cnt, 4);
        chk("prefill_src_ready", bus.src_ready, 0);
        chk("prefill_queue_empty", exp_q.size(), 0);

        rand_v = 1'b1;
        pulse_req();
        wait_beats(40, 200, "line5_beats");
        rand_v = 1'b0;
        bus.src_valid = 1'b0;
        repeat (10) step();
        chk("line5_no_extra", beat_cnt, 40);
        chk("line5_line_cnt", bus.line_cnt, 5);
        chk("line5_src_ready", bus.src_ready, 0);

        pulse_req();
        repeat (4) pulse_req();
        chk("overrun_flag", bus.err_overrun, 1);
        chk("stalled_line_beats", beat_cnt, 40);
        chk("stalled_src_ready", bus.src_ready, 1);
        bus.src_valid = 1'b1;
        wait_beats(72, 300, "three_more_lines");
        repeat (20) step();
        chk("overrun_no_extra", beat_cnt, 72);
        chk("overrun_line_cnt", bus.line_cnt, 9);
        chk("overrun_src_ready", bus.src_ready, 0);
        chk("pad1_consumed", exp_q.size(), 8);

        pulse_req();
        wait_beats(80, 50, "pad2_beats");
        step();
        chk("pad2_line_cnt", bus.line_cnt, 10);
        chk("pad2_queue_empty", exp_q.size(), 0);

        pulse_req();
        repeat (10) step();
        chk("drain_no_beats", beat_cnt, 80);
        chk("drain_busy", bus.busy, 1);
        chk("drain_src_ready", bus.src_ready, 0);

        for (int i = 0; i < W * H; i++) begin
            bus.pixel_out_valid = 1'b1;
            step();
            if (i == W * H - 2) chk("no_early_done", bus.frame_done, 0);
        end
        bus.pixel_out_valid = 1'b0;
        chk("frame_done_pulse", bus.frame_done, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_line_cnt", bus.line_cnt, 0);
        step();
        chk("frame_done_single", bus.frame_done, 0);
        bus.pixel_out_valid = 1'b1;
        repeat (5) step();
        bus.pixel_out_valid = 1'b0;
        step();
        chk("idle_pov_ignored", bus.frame_done, 0);
        chk("idle_pov_busy", bus.busy, 0);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_beats(112, 100, "prefill2_beats");
        pulse_req();
        wait_beats(117, 50, "col5_beats");
        rst = 1'b1;
        step();
        chk("abort_pixel_valid", bus.pixel_valid, 0);
        chk("abort_line_cnt", bus.line_cnt, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_src_ready", bus.src_ready, 0);
        chk("abort_overrun_clr", bus.err_overrun, 0);
        rst = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_beats(32, 100, "reprefill_beats");
        repeat (10) step();
        chk("reprefill_no_extra", beat_cnt, 32);
        chk("reprefill_line_cnt", bus.line_cnt, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/img_line_feed_ctrl.md
Name: img_line_feed_ctrl

Overview:
- Sequences the pixel stream from an upstream source (DMA/FIFO) into img_processing_top_module.
- Prefills the line buffers, then releases one line per pixel_request rising edge, then injects zero padding lines.
- Counts processed output pixels and flags frame completion.
- Replaces the bench/host-side feeding loop with synthesizable control.

Parameters:
IMG_WIDTH, 512, pixels per line
IMG_HEIGHT, 512, lines per frame
PREFILL_LINES, 4, lines sent unconditionally after start
PAD_LINES, 2, zero lines appended after last image line
DATA_W, 8, pixel width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
src_valid  in  1  upstream pixel valid
src_data  in  DATA_W  upstream pixel
src_ready  out  1  upstream accept; beat transfers when src_valid&src_ready
pixel_valid  out  1  to processing core pixel_valid
pixel_input  out  DATA_W  to processing core pixel_input
pixel_request  in  1  from core; rising edge = room for one more line
pixel_out_valid  in  1  from core; one processed pixel
busy  out  1  high from start accept until done
frame_done  out  1  one-cycle pulse when IMG_WIDTH*IMG_HEIGHT outputs counted
line_cnt  out  16  lines fully issued this frame (image + pad)
err_overrun  out  1  sticky; request pending count overflowed

Behaviour:
- Reset: state IDLE; all outputs 0; counters and pending count cleared; pixel_input 0. Reset mid-frame aborts immediately; nothing resumes.
- States: IDLE, PREFILL, WAIT_REQ, SEND_LINE, SEND_PAD, DRAIN.
- IDLE: start -> PREFILL, busy=1. start in any other state is ignored.
- src_ready = 1 only in PREFILL and SEND_LINE (combinational from state).
- Each accepted beat is registered: pixel_valid=1 and pixel_input=src_data in the next cycle. Latency is 1 cycle. pixel_valid=0 on cycles with no accepted beat; bubbles are allowed.
- Pixel column counter 0..IMG_WIDTH-1 increments per issued pixel. On wrap, line_cnt increments.
- PREFILL: after PREFILL_LINES lines -> WAIT_REQ.
- pixel_request edge detect: registered previous value; rising edge increments pending (2-bit, max 3).
- Edge while pending==3: pending holds, err_overrun sets (cleared only by rst).
- Edges are tracked in every non-IDLE state, including mid-line.
- WAIT_REQ, pending>0: decrement pending. Go to SEND_LINE if image lines issued < IMG_HEIGHT, else SEND_PAD if pad lines issued < PAD_LINES, else DRAIN.
- Simultaneous edge and decrement in the same cycle: pending unchanged.
- SEND_LINE: issues IMG_WIDTH src beats, then -> WAIT_REQ.
- SEND_PAD: src_ready=0. pixel_valid=1 and pixel_input=0 for exactly IMG_WIDTH consecutive cycles, then -> WAIT_REQ.
- Output counter counts pixel_out_valid in every non-IDLE state, width $clog2(W*H+1).
- Count reaching IMG_WIDTH*IMG_HEIGHT: frame_done pulses next cycle, busy=0, state -> IDLE, counters cleared.
- This transition happens even if not yet in DRAIN.
- pixel_out_valid in IDLE is ignored.
- Defaults: 4 prefill lines + 508 request-driven lines + 2 pad lines = 514 lines issued; 262144 outputs.

Decomposition:
- Package img_proc_pkg: state enum, IMG_WIDTH/IMG_HEIGHT defaults, derived counter widths via $clog2, pending-count max constant.
- One sub-module, img_req_tracker: rising-edge detect, saturating pending counter, decrement input, overrun flag.

Test Plan:
- Reset/idle: rst high 3 cycles -> all outputs 0. Release without start -> src_ready stays 0 for 100 cycles.
- Prefill, W=8, H=8, src_valid always 1: start -> exactly 32 pixel_valid beats, data equals src_data delayed 1 cycle, line_cnt=4, then src_ready=0 awaiting request.
- Request/backpressure: toggle src_valid 50%, pulse pixel_request -> exactly 8 more beats, order preserved, no beats while src_valid=0.
- Pad and done, W=8, H=8: issue 4 requests after prefill, then 2 more -> 16 beats with pixel_input=0, line_cnt=10. Drive 64 pixel_out_valid -> frame_done single pulse, busy=0.
- Overrun: 4 pixel_request edges during one SEND_LINE -> pending saturates at 3, err_overrun=1. Exactly 3 further lines then issued.
- Mid-frame abort: rst during SEND_LINE at column 5 -> next cycle IDLE, pixel_valid=0, line_cnt=0. A new start performs a full prefill again.
